// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the load/store stage (MEM). Grants are combinational and same-cycle. MEM has
// priority, but a saturating starvation counter forces an IF win after
// STARVE_LIMIT consecutive IF losses. Read returns travel through an RD_LAT-deep
// {valid, owner} tag pipe so ram_rdata is routed to whoever issued the read.
// A branch flush squashes every in-flight IF read, including one granted in
// the flush cycle itself.

module mem_port_arbiter #(
    parameter int AW           = 9,
    parameter int DW           = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_rvalid,
    output logic [DW-1:0] mem_rdata,

    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    // Counter just wide enough to reach STARVE_LIMIT (at least one bit).
    localparam int            SW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT     = SW'(STARVE_LIMIT);
    localparam logic          OWN_IF    = 1'b0;
    localparam logic          OWN_MEM   = 1'b1;
    localparam int            LAST      = RD_LAT - 1;

    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] own_q;
    logic [RD_LAT-1:0] own_d;

    logic              force_if_s;
    logic              if_win_s;
    logic              mem_win_s;
    logic              ram_we_s;
    logic [AW-1:0]     ram_addr_s;
    logic [DW-1:0]     ram_wdata_s;

    // IF is forced to win only when the limit is enabled and has been reached.
    assign force_if_s = (STARVE_LIMIT != 0) && (starve_q == LIMIT);

    // Grant decision: MEM priority with starvation override; nothing while in reset.
    always_comb begin
        if_win_s  = 1'b0;
        mem_win_s = 1'b0;
        if (!rst) begin
            if_win_s  = 1'b0;
            mem_win_s = 1'b0;
        end else if (if_req && mem_req) begin
            if (force_if_s) begin
                if_win_s = 1'b1;
            end else begin
                mem_win_s = 1'b1;
            end
        end else if (if_req) begin
            if_win_s = 1'b1;
        end else if (mem_req) begin
            mem_win_s = 1'b1;
        end else begin
            if_win_s  = 1'b0;
            mem_win_s = 1'b0;
        end
    end

    // RAM command mux from the winner; idle bus is all zeros.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        if (if_win_s) begin
            ram_addr_s = if_addr;
        end else if (mem_win_s) begin
            ram_we_s    = mem_we;
            ram_addr_s  = mem_addr;
            ram_wdata_s = mem_wdata;
        end else begin
            ram_we_s    = 1'b0;
        end
    end

    // Starvation counter: reset by an IF win or IF idle, counts IF losses to MEM.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_win_s) begin
            starve_d = '0;
        end else if (mem_win_s && (starve_q != LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Tag pipe next state: shift, load the new read, then apply the IF flush.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = if_win_s | (mem_win_s & ~mem_we);
        own_d[0] = mem_win_s ? OWN_MEM : OWN_IF;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
        if (if_flush) begin
            for (int i = 0; i < RD_LAT; i++) begin
                if (own_d[i] == OWN_IF) begin
                    vld_d[i] = 1'b0;
                end else begin
                    vld_d[i] = vld_d[i];
                end
            end
        end else begin
            vld_d = vld_d;
        end
    end

    // State registers: starvation counter and return tag pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            vld_q    <= '0;
            own_q    <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q    <= vld_d;
            own_q    <= own_d;
        end
    end

    assign if_gnt     = if_win_s;
    assign mem_gnt    = mem_win_s;
    assign ram_en     = if_win_s | mem_win_s;
    assign ram_we     = ram_we_s;
    assign ram_addr   = ram_addr_s;
    assign ram_wdata  = ram_wdata_s;

    assign if_rvalid  = vld_q[LAST] & (own_q[LAST] == OWN_IF);
    assign mem_rvalid = vld_q[LAST] & (own_q[LAST] == OWN_MEM);
    assign if_rdata   = ram_rdata;
    assign mem_rdata  = ram_rdata;

endmodule
